// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, HLT detection and the IF/ID pipeline register.
// Redirects override stall and halt; reset overrides everything.
module if_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic [15:0] ifid_inst,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic {FETCH, HALTED} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] pc_plus2;
    logic        is_hlt;

    assign pc_plus2  = pc + 16'd2;
    assign is_hlt    = (imem_data[15:12] == 4'hF);
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (branch_taken) begin
            pc_nxt    = branch_target;
            state_nxt = FETCH;
        end else if (!stall && state == FETCH) begin
            // A HLT word parks the PC on itself so a later redirect resumes cleanly.
            if (is_hlt) state_nxt = HALTED;
            else        pc_nxt    = pc_plus2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush || branch_taken) begin
            ifid_valid    <= 1'b0;
            ifid_inst     <= '0;
            ifid_pc_plus2 <= '0;
        end else if (stall) begin
            ifid_valid    <= ifid_valid;
            ifid_inst     <= ifid_inst;
            ifid_pc_plus2 <= ifid_pc_plus2;
        end else if (state == HALTED) begin
            ifid_valid    <= 1'b0;
            ifid_inst     <= '0;
            ifid_pc_plus2 <= '0;
        end else begin
            ifid_valid    <= 1'b1;
            ifid_inst     <= imem_data;
            ifid_pc_plus2 <= pc_plus2;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: each driven cycle pushes the expected post-edge state,
// which is popped and compared one time unit after the rising edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, branch_taken;
    logic [15:0] branch_target, imem_data;
    logic [15:0] imem_addr, pc, ifid_inst, ifid_pc_plus2;
    logic        ifid_valid, halted;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
        logic [15:0] pp2;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state, kept independently of the DUT.
    logic [15:0] m_pc, m_inst, m_pp2;
    logic        m_valid, m_halt;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_data     (imem_data),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .ifid_inst     (ifid_inst),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic fl, input logic bt,
                        input logic [15:0] tgt, input logic [15:0] data);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst_n = ~rst; stall = st; flush = fl; branch_taken = bt;
        branch_target = tgt; imem_data = data;
        check("imem_addr", imem_addr, m_pc);
        check("halted_pre", {15'd0, halted}, {15'd0, m_halt});
        if (rst) begin
            m_pc = 16'h0; m_halt = 1'b0; m_valid = 1'b0; m_inst = 16'h0; m_pp2 = 16'h0;
        end else begin
            if (fl || bt) begin
                m_valid = 1'b0; m_inst = 16'h0; m_pp2 = 16'h0;
            end else if (!st) begin
                if (m_halt) begin
                    m_valid = 1'b0; m_inst = 16'h0; m_pp2 = 16'h0;
                end else begin
                    m_valid = 1'b1; m_inst = data; m_pp2 = m_pc + 16'd2;
                end
            end
            if (bt) begin
                m_pc = tgt; m_halt = 1'b0;
            end else if (!st && !m_halt) begin
                if (data[15:12] == 4'hF) m_halt = 1'b1;
                else                     m_pc   = m_pc + 16'd2;
            end
        end
        e = '{pc: m_pc, inst: m_inst, pp2: m_pp2, valid: m_valid, halt: m_halt};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 16'd0, 16'd1);
        end else begin
            g = exp_q.pop_front();
            check("pc", pc, g.pc);
            check("ifid_inst", ifid_inst, g.inst);
            check("ifid_pc_plus2", ifid_pc_plus2, g.pp2);
            check("ifid_valid", {15'd0, ifid_valid}, {15'd0, g.valid});
            check("halted", {15'd0, halted}, {15'd0, g.halt});
        end
    endtask

    task automatic run(input logic st, input logic fl, input logic bt,
                       input logic [15:0] tgt, input logic [15:0] data);
        step(1'b0, st, fl, bt, tgt, data);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0; imem_data = 16'h0;
        m_pc = 16'h0; m_halt = 1'b0; m_valid = 1'b0; m_inst = 16'h0; m_pp2 = 16'h0;

        // Reset held two cycles, driven against busy control inputs.
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hF000);
        step(1'b1, 1'b0, 1'b0, 0, 16'h0, 16'h0);
        check("rst_pc", pc, 16'h0000);
        check("rst_valid", {15'd0, ifid_valid}, 16'h0);
        check("rst_halted", {15'd0, halted}, 16'h0);
        check("rst_addr", imem_addr, 16'h0000);

        run(0, 0, 0, 16'h0, 16'h1234);
        check("f1_pc", pc, 16'h0002);
        check("f1_inst", ifid_inst, 16'h1234);
        check("f1_pp2", ifid_pc_plus2, 16'h0002);
        check("f1_valid", {15'd0, ifid_valid}, 16'h1);

        run(0, 0, 0, 16'h0, 16'h2000);
        run(0, 0, 0, 16'h0, 16'h3000);
        check("pre_stall_pc", pc, 16'h0006);
        for (int i = 0; i < 3; i++) begin
            run(1, 0, 0, 16'h0, 16'h4444);
            check("stall_pc", pc, 16'h0006);
            check("stall_inst", ifid_inst, 16'h3000);
        end
        run(0, 0, 0, 16'h0, 16'h4444);
        check("post_stall_pc", pc, 16'h0008);
        check("post_stall_inst", ifid_inst, 16'h4444);

        run(1, 1, 1, 16'h0040, 16'h5555);
        check("redir_pc", pc, 16'h0040);
        check("redir_valid", {15'd0, ifid_valid}, 16'h0);

        run(0, 1, 0, 16'h0, 16'h6666);
        run(1, 1, 0, 16'h0, 16'h7777);
        check("flush_stall_pc", pc, 16'h0042);
        check("flush_stall_valid", {15'd0, ifid_valid}, 16'h0);

        run(0, 0, 1, 16'h0010, 16'h0);
        run(0, 0, 0, 16'h0, 16'hF000);
        check("hlt_inst", ifid_inst, 16'hF000);
        check("hlt_valid", {15'd0, ifid_valid}, 16'h1);
        check("hlt_pc", pc, 16'h0010);
        check("hlt_halted", {15'd0, halted}, 16'h1);
        run(0, 0, 0, 16'h0, 16'h1111);
        check("halt_bubble", {15'd0, ifid_valid}, 16'h0);
        check("halt_pc", pc, 16'h0010);
        run(1, 0, 0, 16'h0, 16'h2222);
        run(0, 1, 0, 16'h0, 16'h3333);
        run(0, 0, 1, 16'h0020, 16'hF000);
        check("resume_halted", {15'd0, halted}, 16'h0);
        check("resume_pc", pc, 16'h0020);

        run(0, 0, 1, 16'hFFFE, 16'h0);
        run(0, 0, 0, 16'h0, 16'h0ABC);
        check("wrap_pc", pc, 16'h0000);
        check("wrap_pp2", ifid_pc_plus2, 16'h0000);

        run(0, 0, 0, 16'h0, 16'hF123);
        run(1, 0, 0, 16'h0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hF000);
        check("halt_rst_pc", pc, 16'h0000);
        check("halt_rst_halted", {15'd0, halted}, 16'h0);
        check("halt_rst_valid", {15'd0, ifid_valid}, 16'h0);
        check("halt_rst_inst", ifid_inst, 16'h0000);

        run(1, 0, 0, 16'h0, 16'h1000);
        step(1'b1, 1'b1, 0, 0, 16'h0, 16'h1000);
        check("stall_rst_pc", pc, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d[15:12] = 4'hF;
            step($urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 16'($urandom) & 16'hFFFE, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
